// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for the 5-stage core: EXE/MEM/WB scoreboard, ID stall,
// branch flush, memory-wait pipe freeze with timeout, and EXE operand forwarding selects.

// Per-operand dependency check: ID-side stall contribution and EXE-side forward select.
module hcu_operand #(
  parameter int RA_W   = 4,
  parameter int FWD_EN = 1
) (
  input  logic            id_use,
  input  logic [RA_W-1:0] id_src,
  input  logic            exe_use,
  input  logic [RA_W-1:0] exe_src,
  input  logic            exe_wr,
  input  logic            exe_ld,
  input  logic [RA_W-1:0] exe_dest,
  input  logic            mem_wr,
  input  logic            mem_ld,
  input  logic [RA_W-1:0] mem_dest,
  input  logic            wb_wr,
  input  logic [RA_W-1:0] wb_dest,
  output logic            stall,
  output logic [1:0]      fwd_sel
);
  logic hit_exe, hit_mem, fwd_mem, fwd_wb;

  assign hit_exe = id_use && exe_wr && (exe_dest == id_src);
  assign hit_mem = id_use && mem_wr && (mem_dest == id_src);
  assign stall   = (FWD_EN != 0) ? (hit_exe && exe_ld) : (hit_exe || hit_mem);

  // A load sitting in MEM has no result yet; the load-use stall keeps it out of reach.
  assign fwd_mem = exe_use && mem_wr && !mem_ld && (mem_dest == exe_src);
  assign fwd_wb  = exe_use && wb_wr && (wb_dest == exe_src);

  always_comb begin
    fwd_sel = 2'b00;
    if (FWD_EN != 0) begin
      if (fwd_mem)     fwd_sel = 2'b01;
      else if (fwd_wb) fwd_sel = 2'b10;
    end
  end
endmodule

module hazard_ctrl_unit #(
  parameter int RA_W    = 4,
  parameter int FWD_EN  = 1,
  parameter int MEM_TMO = 15,
  parameter int TMO_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic             id_use_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_use_src2,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             id_freeze,
  output logic             pipe_freeze,
  output logic             flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wb_en;
    logic            mem_r;
    logic            mem_w;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
    logic            use1;
    logic            use2;
  } sb_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} mem_st_t;

  sb_entry_t exe_q, mem_q, wb_q, id_ent;
  mem_st_t   st_q, st_nx;
  logic [TMO_W-1:0] cnt_q, cnt_nx;
  logic mem_op, hazard;

  logic [1:0]           op_id_use, op_exe_use, op_stall;
  logic [1:0][RA_W-1:0] op_id_src, op_exe_src;
  logic [1:0][1:0]      op_fwd;

  assign id_ent = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en, mem_r: id_mem_r_en,
                    mem_w: id_mem_w_en, src1: id_src1, src2: id_src2,
                    use1: id_use_src1, use2: id_use_src2};

  assign op_id_use  = {id_use_src2, id_use_src1};
  assign op_id_src  = {id_src2, id_src1};
  assign op_exe_use = {exe_q.valid && exe_q.use2, exe_q.valid && exe_q.use1};
  assign op_exe_src = {exe_q.src2, exe_q.src1};

  for (genvar g = 0; g < 2; g++) begin : g_op
    hcu_operand #(.RA_W(RA_W), .FWD_EN(FWD_EN)) u_op (
      .id_use   (op_id_use[g]),
      .id_src   (op_id_src[g]),
      .exe_use  (op_exe_use[g]),
      .exe_src  (op_exe_src[g]),
      .exe_wr   (exe_q.valid && exe_q.wb_en),
      .exe_ld   (exe_q.mem_r),
      .exe_dest (exe_q.dest),
      .mem_wr   (mem_q.valid && mem_q.wb_en),
      .mem_ld   (mem_q.mem_r),
      .mem_dest (mem_q.dest),
      .wb_wr    (wb_q.valid && wb_q.wb_en),
      .wb_dest  (wb_q.dest),
      .stall    (op_stall[g]),
      .fwd_sel  (op_fwd[g])
    );
  end

  assign hazard    = |op_stall;
  assign flush     = branch_taken && !pipe_freeze;
  assign id_freeze = id_valid && hazard && !flush;
  assign fwd_sel1  = op_fwd[0];
  assign fwd_sel2  = op_fwd[1];

  assign mem_op      = mem_q.valid && (mem_q.mem_r || mem_q.mem_w);
  assign mem_timeout = (st_q == ST_ERR);

  // The ready cycle releases the pipe so the completed access advances to WB.
  always_comb begin
    st_nx       = st_q;
    cnt_nx      = cnt_q;
    pipe_freeze = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (mem_op && !mem_ready) begin
          pipe_freeze = 1'b1;
          st_nx       = ST_WAIT;
          cnt_nx      = TMO_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          st_nx  = ST_IDLE;
          cnt_nx = '0;
        end else begin
          pipe_freeze = 1'b1;
          if (cnt_q == TMO_W'(MEM_TMO)) st_nx = ST_ERR;
          else                          cnt_nx = cnt_q + TMO_W'(1);
        end
      end
      ST_ERR:  pipe_freeze = 1'b1;
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!pipe_freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= (id_valid && !id_freeze && !flush) ? id_ent : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((id_freeze || pipe_freeze) && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // WB only needs to be visible as a write-back source; its other fields just ride along.
  logic unused_wb;
  assign unused_wb = ^{wb_q.mem_r, wb_q.mem_w, wb_q.src1, wb_q.src2, wb_q.use1, wb_q.use2};
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: FWD_EN=1 and FWD_EN=0 instances share stimulus and are
// checked every cycle against an instruction-level pipeline model.
module tb_hazard_ctrl_unit;
  localparam int MEM_TMO = 15;
  localparam int SAT     = 65535;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en, id_mem_w_en;
  logic branch_taken, mem_ready;
  logic [3:0] id_src1, id_src2, id_dest;

  // index 1: FWD_EN=1, index 0: FWD_EN=0
  logic [1:0] ifz, pfz, fl, tmo;
  logic [1:0][1:0] fs1, fs2;
  logic [1:0][15:0] sc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.RA_W(4), .FWD_EN(1), .MEM_TMO(MEM_TMO), .TMO_W(4), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .id_freeze(ifz[1]), .pipe_freeze(pfz[1]), .flush(fl[1]), .fwd_sel1(fs1[1]), .fwd_sel2(fs2[1]),
    .mem_timeout(tmo[1]), .stall_cnt(sc[1]));

  hazard_ctrl_unit #(.RA_W(4), .FWD_EN(0), .MEM_TMO(MEM_TMO), .TMO_W(4), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .id_freeze(ifz[0]), .pipe_freeze(pfz[0]), .flush(fl[0]), .fwd_sel1(fs1[0]), .fwd_sel2(fs2[0]),
    .mem_timeout(tmo[0]), .stall_cnt(sc[0]));

  // ---------------- reference model: instructions in flight, stage 0=EXE 1=MEM 2=WB
  typedef struct { bit v, wb, ld, st, u1, u2; int d, s1, s2; } ins_t;
  ins_t mp[2][3];
  int   mw[2];   // consecutive not-ready cycles of the access in MEM
  bit   mt[2];   // timed out
  int   ms[2];   // stall cycles

  function automatic ins_t id_ins();
    ins_t e;
    e.v = id_valid; e.wb = id_wb_en; e.ld = id_mem_r_en; e.st = id_mem_w_en;
    e.u1 = id_use_src1; e.u2 = id_use_src2;
    e.d = int'(id_dest); e.s1 = int'(id_src1); e.s2 = int'(id_src2);
    return e;
  endfunction

  function automatic bit writes(ins_t e, int r);
    return e.v && e.wb && e.d == r;
  endfunction

  function automatic bit depends(ins_t i, ins_t e);
    return (i.u1 && writes(e, i.s1)) || (i.u2 && writes(e, i.s2));
  endfunction

  function automatic bit m_pfrz(int k);
    return mt[k] || (mp[k][1].v && (mp[k][1].ld || mp[k][1].st) && !mem_ready);
  endfunction

  function automatic bit m_flush(int k);
    return branch_taken && !m_pfrz(k);
  endfunction

  function automatic bit m_ifrz(int k);
    ins_t i = id_ins();
    bit h;
    if (k == 1) h = depends(i, mp[k][0]) && mp[k][0].ld;
    else        h = depends(i, mp[k][0]) || depends(i, mp[k][1]);
    return id_valid && h && !m_flush(k);
  endfunction

  function automatic int m_fsel(int k, int n);
    ins_t x = mp[k][0];
    bit   u = (n == 1) ? x.u1 : x.u2;
    int   s = (n == 1) ? x.s1 : x.s2;
    if (k == 0 || !x.v || !u) return 0;
    if (writes(mp[k][1], s) && !mp[k][1].ld) return 1;
    if (writes(mp[k][2], s)) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin : upd
      ins_t empty;
      bit pf, fz, flb, memop;
      empty = '{default: 0};
      if (rst) begin
        for (int s = 0; s < 3; s++) mp[k][s] = empty;
        mw[k] = 0; mt[k] = 0; ms[k] = 0;
      end else begin
        pf = m_pfrz(k); fz = m_ifrz(k); flb = m_flush(k);
        memop = mp[k][1].v && (mp[k][1].ld || mp[k][1].st);
        if (fz || pf) ms[k] = (ms[k] + 1 > SAT) ? SAT : ms[k] + 1;
        if (!mt[k]) begin
          if (memop && !mem_ready) begin
            mw[k] = mw[k] + 1;
            if (mw[k] > MEM_TMO) mt[k] = 1;
          end else mw[k] = 0;
        end
        if (!pf) begin
          mp[k][2] = mp[k][1];
          mp[k][1] = mp[k][0];
          mp[k][0] = (id_valid && !fz && !flb) ? id_ins() : empty;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.id_freeze", k),   32'(ifz[k]), 32'(m_ifrz(k)));
        chk($sformatf("u%0d.pipe_freeze", k), 32'(pfz[k]), 32'(m_pfrz(k)));
        chk($sformatf("u%0d.flush", k),       32'(fl[k]),  32'(m_flush(k)));
        chk($sformatf("u%0d.fwd_sel1", k),    32'(fs1[k]), 32'(m_fsel(k, 1)));
        chk($sformatf("u%0d.fwd_sel2", k),    32'(fs2[k]), 32'(m_fsel(k, 2)));
        chk($sformatf("u%0d.mem_timeout", k), 32'(tmo[k]), 32'(mt[k]));
        chk($sformatf("u%0d.stall_cnt", k),   32'(sc[k]),  32'(ms[k]));
      end
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int d, int s1, int s2, bit u1, bit u2, bit wb, bit ld, bit st);
    id_valid = 1; id_dest = 4'(d); id_src1 = 4'(s1); id_src2 = 4'(s2);
    id_use_src1 = u1; id_use_src2 = u2; id_wb_en = wb; id_mem_r_en = ld; id_mem_w_en = st;
  endtask

  task automatic bubble();
    id_valid = 0; id_dest = 0; id_src1 = 0; id_src2 = 0;
    id_use_src1 = 0; id_use_src2 = 0; id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0;
  endtask

  task automatic do_reset();
    rst = 1; bubble(); branch_taken = 0; mem_ready = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic drain();
    bubble();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1; branch_taken = 0; mem_ready = 1;
    bubble();
    #1;
    do_reset();

    #3;
    chk("rst.id_freeze", 32'(ifz[1]), 0);
    chk("rst.pipe_freeze", 32'(pfz[1]), 0);
    chk("rst.stall_cnt", 32'(sc[1]), 0);
    chk("rst.mem_timeout", 32'(tmo[1]), 0);
    tick();

    // ADD r1,r2,r3 ; SUB r2,r1,r3
    issue(1, 2, 3, 1, 1, 1, 0, 0); tick();
    issue(2, 1, 3, 1, 1, 1, 0, 0); #3;
    chk("t1.no_stall", 32'(ifz[1]), 0);
    chk("t1.nofwd_stall", 32'(ifz[0]), 1);
    tick(); bubble(); #3;
    chk("t1.fwd_sel1", 32'(fs1[1]), 1);
    chk("t1.fwd_sel2", 32'(fs2[1]), 0);
    drain();

    // LDR r4 ; ADD r5,r4,r4
    issue(4, 0, 0, 1, 0, 1, 1, 0); tick();
    issue(5, 4, 4, 1, 1, 1, 0, 0); #3;
    chk("t2.load_use", 32'(ifz[1]), 1);
    tick(); #3;
    chk("t2.released", 32'(ifz[1]), 0);
    chk("t2.stall_cnt", 32'(sc[1]), 1);
    tick(); bubble(); #3;
    chk("t2.fwd_sel1", 32'(fs1[1]), 2);
    chk("t2.fwd_sel2", 32'(fs2[1]), 2);
    drain();

    // FWD_EN=0: ADD r1 ; MOV r2,r1
    issue(1, 2, 3, 1, 1, 1, 0, 0); tick();
    issue(2, 0, 1, 0, 1, 1, 0, 0); #3;
    chk("t3.stall_a", 32'(ifz[0]), 1);
    chk("t3.fwd_a", 32'(fs1[0]), 0);
    tick(); #3;
    chk("t3.stall_b", 32'(ifz[0]), 1);
    tick(); #3;
    chk("t3.stall_end", 32'(ifz[0]), 0);
    tick(); bubble(); #3;
    chk("t3.fwd_b", 32'(fs2[0]), 0);
    drain();

    // branch over a pending load-use
    issue(4, 0, 0, 1, 0, 1, 1, 0); tick();
    issue(5, 4, 0, 1, 0, 1, 0, 0); branch_taken = 1; #3;
    chk("t4.flush", 32'(fl[1]), 1);
    chk("t4.no_freeze", 32'(ifz[1]), 0);
    tick(); branch_taken = 0;
    issue(6, 5, 0, 1, 0, 1, 0, 0); #3;
    chk("t4.after", 32'(ifz[1]), 0);
    tick(); bubble(); #3;
    chk("t4.bubble", 32'(fs1[1]), 0);
    drain();

    // LDR r6 held 3 cycles in MEM, ADD r7,r6 waiting in ID
    issue(6, 0, 0, 1, 0, 1, 1, 0); tick();
    bubble(); tick();
    issue(7, 6, 0, 1, 0, 1, 0, 0); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #3; chk("t5.freeze", 32'(pfz[1]), 1);
      tick();
    end
    mem_ready = 1; #3;
    chk("t5.release", 32'(pfz[1]), 0);
    chk("t5.stall_cnt", 32'(sc[1]), 4);
    tick(); bubble(); #3;
    chk("t5.fwd_wb", 32'(fs1[1]), 2);
    drain();

    // timeout
    issue(8, 0, 0, 1, 0, 1, 1, 0); tick();
    bubble(); tick();
    mem_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      #3;
      if (i == 16) chk("t5.tmo_edge", 32'(tmo[1]), 0);
      tick();
    end
    #3;
    chk("t5.timeout", 32'(tmo[1]), 1);
    mem_ready = 1; tick(); #3;
    chk("t5.sticky", 32'(tmo[1]), 1);
    chk("t5.err_freeze", 32'(pfz[1]), 1);
    tick();

    // reset during WAIT
    do_reset();
    issue(9, 0, 0, 1, 0, 1, 1, 0); tick();
    bubble(); tick();
    mem_ready = 0;
    repeat (3) tick();
    rst = 1; tick(); rst = 0; #3;
    chk("t6.pfz", 32'(pfz[1]), 0);
    chk("t6.tmo", 32'(tmo[1]), 0);
    chk("t6.cnt", 32'(sc[1]), 0);
    tick(); mem_ready = 1;

    // random traffic
    repeat (3000) begin
      rst          = ($urandom_range(0, 249) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_dest      = 4'($urandom_range(0, 3));
      id_use_src1  = 1'($urandom_range(0, 1));
      id_use_src2  = 1'($urandom_range(0, 1));
      id_wb_en     = ($urandom_range(0, 3) != 0);
      id_mem_r_en  = ($urandom_range(0, 3) == 0);
      id_mem_w_en  = !id_mem_r_en && ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_ready    = ($urandom_range(0, 5) != 0);
      tick();
    end

    // permanent freeze: counter saturation
    do_reset();
    issue(1, 0, 0, 1, 0, 1, 1, 0); tick();
    bubble(); tick();
    mem_ready = 0;
    repeat (65600) tick();
    #3;
    chk("t6.sat", 32'(sc[1]), SAT);
    chk("t6.sat_nofwd", 32'(sc[0]), SAT);
    tick(); #3;
    chk("t6.sat_hold", 32'(sc[1]), SAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
